// File: rtl/conv_feature_rdma.sv
// Read DMA for the CONV input feature map. Walks a Tout-packed surface
// (burst within line, then line, then channel group), issues MCIF read bursts
// guarded by FIFO credits, buffers responses, and streams pixels to CONV.
//
// Handshakes: every valid/ready pair transfers in a cycle where both are high
// at the rising clock edge; a producer holds valid and payload stable until
// that transfer happens.
module conv_feature_rdma #(
  parameter int TOUT       = 32,
  parameter int DAT_DW     = 8,
  parameter int LOG2_W     = 12,
  parameter int LOG2_H     = 12,
  parameter int LOG2_CHT   = 8,
  parameter int LOG2_BURST = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdma_start,
  input  logic [LOG2_W-1:0]            w_rdma,
  input  logic [LOG2_H-1:0]            h_rdma,
  input  logic [LOG2_CHT-1:0]          ch_rdma_div_Tout,
  input  logic [31:0]                  feature_rdma_base_addr,
  input  logic [31:0]                  feature_rdma_surface_stride,
  input  logic [15:0]                  feature_rdma_line_stride,
  output logic                         rdma_done,
  output logic                         mcif_rd_req_vld,
  input  logic                         mcif_rd_req_rdy,
  output logic [32+LOG2_BURST-1:0]     mcif_rd_req_pd,
  input  logic                         mcif_rd_rsp_vld,
  output logic                         mcif_rd_rsp_rdy,
  input  logic [TOUT*DAT_DW-1:0]       mcif_rd_rsp_pd,
  output logic                         dat_out_vld,
  input  logic                         dat_out_rdy,
  output logic [TOUT*DAT_DW-1:0]       dat_out_pd,
  output logic                         dat_out_last,
  output logic [1:0]                   dbg_state
);

  localparam int PW        = TOUT * DAT_DW;
  localparam int PIX_BYTES = PW / 8;
  localparam int BURST     = 1 << LOG2_BURST;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int TW        = LOG2_W + LOG2_H + LOG2_CHT;
  localparam logic [31:0] BURST_BYTES = 32'(BURST * PIX_BYTES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMD = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [LOG2_H-1:0]     height_q, height_d;
  logic [LOG2_CHT-1:0]   ch_div_q, ch_div_d;
  logic [LOG2_BURST-1:0] tail_len_q, tail_len_d;
  logic [LOG2_W-1:0]     nb_q, nb_d;
  logic [15:0]           line_stride_q, line_stride_d;
  logic [31:0]           surf_stride_q, surf_stride_d;
  logic [LOG2_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [LOG2_H-1:0]     h_cnt_q, h_cnt_d;
  logic [LOG2_CHT-1:0]   ch_cnt_q, ch_cnt_d;
  logic [31:0]           surf_addr_q, surf_addr_d;
  logic [31:0]           line_addr_q, line_addr_d;
  logic [31:0]           burst_addr_q, burst_addr_d;
  logic [CW-1:0]         free_q, free_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]         out_cnt_q, out_cnt_d;
  logic [TW-1:0]         total_m1_q, total_m1_d;
  logic                  done_q, done_d;

  logic [PW-1:0]         fifo_mem [FIFO_DEPTH];

  logic                  last_burst, last_line, last_ch;
  logic [LOG2_BURST-1:0] cmd_len;
  logic [CW-1:0]         beats;
  logic                  req_hs, push, pop, fifo_full, fifo_empty;
  logic [31:0]           next_surf, next_line;

  // Command shape and handshake decode from the walk counters and FIFO pointers.
  always_comb begin
    last_burst = (burst_cnt_q == nb_q - LOG2_W'(1));
    last_line  = (h_cnt_q == height_q - LOG2_H'(1));
    last_ch    = (ch_cnt_q == ch_div_q - LOG2_CHT'(1));
    cmd_len    = last_burst ? tail_len_q : LOG2_BURST'(BURST - 1);
    beats      = CW'(cmd_len) + CW'(1);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    mcif_rd_req_vld = (state_q == S_CMD) && (free_q >= beats);
    mcif_rd_req_pd  = (state_q == S_CMD) ? {cmd_len, burst_addr_q} : '0;
    mcif_rd_rsp_rdy = !fifo_full;
    dat_out_vld     = !fifo_empty;
    dat_out_pd      = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    dat_out_last    = dat_out_vld && (out_cnt_q == total_m1_q);
    rdma_done       = done_q;
    dbg_state       = state_q;
    req_hs          = mcif_rd_req_vld && mcif_rd_req_rdy;
    push            = mcif_rd_rsp_vld && !fifo_full;
    pop             = dat_out_vld && dat_out_rdy;
    next_surf       = surf_addr_q + surf_stride_q;
    next_line       = line_addr_q + {16'h0, line_stride_q};
  end

  // Next-state: FSM, address walk (running sums), credits and output count.
  always_comb begin
    state_d       = state_q;
    height_d      = height_q;
    ch_div_d      = ch_div_q;
    tail_len_d    = tail_len_q;
    nb_d          = nb_q;
    line_stride_d = line_stride_q;
    surf_stride_d = surf_stride_q;
    burst_cnt_d   = burst_cnt_q;
    h_cnt_d       = h_cnt_q;
    ch_cnt_d      = ch_cnt_q;
    surf_addr_d   = surf_addr_q;
    line_addr_d   = line_addr_q;
    burst_addr_d  = burst_addr_q;
    total_m1_d    = total_m1_q;
    done_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    out_cnt_d     = out_cnt_q + TW'(pop);
    free_d        = free_q - (req_hs ? beats : CW'(0)) + CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (rdma_start) begin
          height_d      = h_rdma;
          ch_div_d      = ch_rdma_div_Tout;
          tail_len_d    = w_rdma[LOG2_BURST-1:0] - LOG2_BURST'(1);
          nb_d          = LOG2_W'(w_rdma >> LOG2_BURST) + LOG2_W'(|w_rdma[LOG2_BURST-1:0]);
          line_stride_d = feature_rdma_line_stride;
          surf_stride_d = feature_rdma_surface_stride;
          burst_cnt_d   = '0;
          h_cnt_d       = '0;
          ch_cnt_d      = '0;
          surf_addr_d   = feature_rdma_base_addr;
          line_addr_d   = feature_rdma_base_addr;
          burst_addr_d  = feature_rdma_base_addr;
          out_cnt_d     = '0;
          total_m1_d    = TW'(w_rdma) * TW'(h_rdma) * TW'(ch_rdma_div_Tout) - TW'(1);
          // An empty job completes immediately without touching MCIF.
          if (w_rdma == '0 || h_rdma == '0 || ch_rdma_div_Tout == '0) done_d = 1'b1;
          else state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (req_hs) begin
          if (!last_burst) begin
            burst_cnt_d  = burst_cnt_q + LOG2_W'(1);
            burst_addr_d = burst_addr_q + BURST_BYTES;
          end else begin
            burst_cnt_d = '0;
            if (!last_line) begin
              h_cnt_d      = h_cnt_q + LOG2_H'(1);
              line_addr_d  = next_line;
              burst_addr_d = next_line;
            end else begin
              h_cnt_d      = '0;
              ch_cnt_d     = ch_cnt_q + LOG2_CHT'(1);
              surf_addr_d  = next_surf;
              line_addr_d  = next_surf;
              burst_addr_d = next_surf;
              if (last_ch) state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (pop && dat_out_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      height_q      <= '0;
      ch_div_q      <= '0;
      tail_len_q    <= '0;
      nb_q          <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      burst_cnt_q   <= '0;
      h_cnt_q       <= '0;
      ch_cnt_q      <= '0;
      surf_addr_q   <= '0;
      line_addr_q   <= '0;
      burst_addr_q  <= '0;
      free_q        <= CW'(FIFO_DEPTH);
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_cnt_q     <= '0;
      total_m1_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      height_q      <= height_d;
      ch_div_q      <= ch_div_d;
      tail_len_q    <= tail_len_d;
      nb_q          <= nb_d;
      line_stride_q <= line_stride_d;
      surf_stride_q <= surf_stride_d;
      burst_cnt_q   <= burst_cnt_d;
      h_cnt_q       <= h_cnt_d;
      ch_cnt_q      <= ch_cnt_d;
      surf_addr_q   <= surf_addr_d;
      line_addr_q   <= line_addr_d;
      burst_addr_q  <= burst_addr_d;
      free_q        <= free_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      out_cnt_q     <= out_cnt_d;
      total_m1_q    <= total_m1_d;
      done_q        <= done_d;
    end
  end

  // Response buffer storage; contents are only visible through the read pointer.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= mcif_rd_rsp_pd;
  end

endmodule

// File: tb/tb_conv_feature_rdma.sv
// Bench for conv_feature_rdma: table of jobs driven through an MCIF responder
// model and a CONV sink, checked against an address-walk reference model.
module tb_conv_feature_rdma;

  localparam int PW = 256;
  localparam int FD = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdma_start = 1'b0;
  logic [11:0]     w_rdma = '0;
  logic [11:0]     h_rdma = '0;
  logic [7:0]      ch_rdma_div_Tout = '0;
  logic [31:0]     base_addr = '0;
  logic [31:0]     surf_stride = '0;
  logic [15:0]     line_stride = '0;
  logic            rdma_done;
  logic            req_vld;
  logic            req_rdy = 1'b0;
  logic [35:0]     req_pd;
  logic            rsp_vld = 1'b0;
  logic            rsp_rdy;
  logic [PW-1:0]   rsp_pd = '0;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [PW-1:0]   out_pd;
  logic            out_last;
  logic [1:0]      dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  conv_feature_rdma #(
    .TOUT(32), .DAT_DW(8), .LOG2_W(12), .LOG2_H(12), .LOG2_CHT(8),
    .LOG2_BURST(4), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .rdma_start(rdma_start),
    .w_rdma(w_rdma), .h_rdma(h_rdma), .ch_rdma_div_Tout(ch_rdma_div_Tout),
    .feature_rdma_base_addr(base_addr),
    .feature_rdma_surface_stride(surf_stride),
    .feature_rdma_line_stride(line_stride),
    .rdma_done(rdma_done),
    .mcif_rd_req_vld(req_vld), .mcif_rd_req_rdy(req_rdy), .mcif_rd_req_pd(req_pd),
    .mcif_rd_rsp_vld(rsp_vld), .mcif_rd_rsp_rdy(rsp_rdy), .mcif_rd_rsp_pd(rsp_pd),
    .dat_out_vld(out_vld), .dat_out_rdy(out_rdy), .dat_out_pd(out_pd),
    .dat_out_last(out_last), .dbg_state(dbg_state)
  );

  typedef struct {
    int          w, h, ch;
    logic [31:0] base, ss;
    logic [15:0] ls;
    int          req_pct, rsp_pct, out_pct;
    int          restart_cyc, hold_cyc, hold_cmds, abort_cmds;
    int          exp_ncmds, exp_npix;
    logic [35:0] exp_first, exp_last;
  } job_t;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_cmd_q[$];
  logic [31:0] exp_pix_q[$];
  logic [31:0] rsp_q[$];
  job_t        jobs[9];
  job_t        rj;

  function automatic job_t mk(input int w, h, ch, input logic [31:0] base, ss,
                              input logic [15:0] ls, input int rq, rs, ou,
                              input int restart, hold, hold_cmds, abort_n,
                              input int ncmds, npix, input logic [35:0] first, last);
    job_t j;
    j.w = w; j.h = h; j.ch = ch; j.base = base; j.ss = ss; j.ls = ls;
    j.req_pct = rq; j.rsp_pct = rs; j.out_pct = ou;
    j.restart_cyc = restart; j.hold_cyc = hold; j.hold_cmds = hold_cmds;
    j.abort_cmds = abort_n; j.exp_ncmds = ncmds; j.exp_npix = npix;
    j.exp_first = first; j.exp_last = last;
    return j;
  endfunction

  // Pixel content the memory model returns for a byte address.
  function automatic logic [PW-1:0] pix_of(input logic [31:0] a);
    logic [PW-1:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'h01010101 * 32'(i)) ^ 32'(i);
    return p;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: nested walk over channel group, line, burst / pixel.
  task automatic build_model(input job_t j);
    int nb, len;
    exp_cmd_q.delete();
    exp_pix_q.delete();
    if (j.w == 0 || j.h == 0 || j.ch == 0) return;
    nb = (j.w + 15) / 16;
    for (int c = 0; c < j.ch; c++)
      for (int y = 0; y < j.h; y++) begin
        for (int b = 0; b < nb; b++) begin
          len = (b == nb - 1) ? (j.w - 1) % 16 : 15;
          exp_cmd_q.push_back({4'(len), j.base + 32'(c) * j.ss + 32'(y) * {16'h0, j.ls} + 32'(b) * 32'd512});
        end
        for (int x = 0; x < j.w; x++)
          exp_pix_q.push_back(j.base + 32'(c) * j.ss + 32'(y) * {16'h0, j.ls} + 32'(x) * 32'd32);
      end
  endtask

  // driver: random MCIF/CONV handshakes for the next cycle
  task automatic drive_random(input job_t j, input int c);
    req_rdy = ($urandom_range(99) < j.req_pct);
    if (rsp_q.size() > 0 && $urandom_range(99) < j.rsp_pct) begin
      rsp_vld = 1'b1;
      rsp_pd  = pix_of(rsp_q[0]);
    end else begin
      rsp_vld = 1'b0;
      rsp_pd  = {8{$urandom()}};
    end
    out_rdy = (c < j.hold_cyc) ? 1'b0 : ($urandom_range(99) < j.out_pct);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(!req_vld, {tag, "_req_vld"}, 64'(req_vld), 0);
    check(req_pd == '0, {tag, "_req_pd"}, 64'(req_pd), 0);
    check(rsp_rdy, {tag, "_rsp_rdy"}, 64'(rsp_rdy), 1);
    check(!out_vld, {tag, "_out_vld"}, 64'(out_vld), 0);
    check(out_pd == '0, {tag, "_out_pd"}, out_pd[63:0], 0);
    check(!out_last, {tag, "_out_last"}, 64'(out_last), 0);
    check(!rdma_done, {tag, "_done"}, 64'(rdma_done), 0);
    check(dbg_state == 2'd0, {tag, "_state"}, 64'(dbg_state), 0);
  endtask

  task automatic run_job(input job_t j);
    int cyc, ncmd, npix, total, done_cnt, done_cyc, last_pop_cyc, exp_done;
    bit finished, aborted, prev_stall, zero;
    logic [35:0] prev_pd, first_cmd, last_cmd, got, exp_c;
    logic [31:0] a;
    build_model(j);
    total = exp_pix_q.size();
    zero = (total == 0);
    rsp_q.delete();
    cyc = 0; ncmd = 0; npix = 0; done_cnt = 0; done_cyc = -100; last_pop_cyc = -100;
    finished = 0; aborted = 0; prev_stall = 0; prev_pd = '0; first_cmd = '0; last_cmd = '0;
    @(posedge clk); #1;
    w_rdma = 12'(j.w); h_rdma = 12'(j.h); ch_rdma_div_Tout = 8'(j.ch);
    base_addr = j.base; surf_stride = j.ss; line_stride = j.ls;
    rdma_start = 1'b1;
    drive_random(j, 0);
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      if (cyc == 1) begin
        check(req_vld == !zero, "first_req_vld", 64'(req_vld), 64'(!zero));
        check(rdma_done == zero, "empty_job_done", 64'(rdma_done), 64'(zero));
      end
      if (zero) check(!req_vld, "empty_job_no_req", 64'(req_vld), 0);
      if (zero && cyc == 2) check(dbg_state == 2'd0, "empty_job_idle", 64'(dbg_state), 0);
      if (j.hold_cyc > 0 && cyc >= 2 && cyc <= j.hold_cyc)
        check(!req_vld, "credit_block_req", 64'(req_vld), 0);
      if (j.hold_cyc > 0 && cyc == j.hold_cyc)
        check(ncmd == j.hold_cmds, "credit_block_cmds", 64'(ncmd), 64'(j.hold_cmds));
      if (prev_stall)
        check(req_vld && req_pd == prev_pd, "req_pd_stable", {27'h0, req_vld, req_pd}, {28'h1, prev_pd});
      prev_stall = req_vld && !req_rdy;
      prev_pd = req_pd;
      if (rsp_vld) check(rsp_rdy, "rsp_overflow", 64'(rsp_rdy), 1);
      if (req_vld && req_rdy) begin
        got = req_pd;
        if (ncmd == 0) first_cmd = got;
        last_cmd = got;
        ncmd++;
        if (exp_cmd_q.size() == 0) check(1'b0, "cmd_extra", 64'(got), 0);
        else begin
          exp_c = exp_cmd_q.pop_front();
          check(got == exp_c, "cmd", 64'(got), 64'(exp_c));
        end
        for (int k = 0; k <= int'(got[35:32]); k++) rsp_q.push_back(got[31:0] + 32'(k) * 32'd32);
      end
      if (rsp_vld && rsp_rdy && rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (out_vld && out_rdy) begin
        if (exp_pix_q.size() == 0) check(1'b0, "pix_extra", out_pd[63:0], 0);
        else begin
          a = exp_pix_q.pop_front();
          check(out_pd == pix_of(a), "pix", out_pd[63:0], pix_of(a) >> 0);
        end
        check(out_last == (npix == total - 1), "pix_last", 64'(out_last), 64'(npix == total - 1));
        if (out_last) last_pop_cyc = cyc;
        npix++;
      end
      if (rdma_done) begin
        exp_done = zero ? 1 : last_pop_cyc + 1;
        check(cyc == exp_done, "done_timing", 64'(cyc), 64'(exp_done));
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 4) finished = 1;
      @(posedge clk); #1;
      if (j.abort_cmds > 0 && ncmd >= j.abort_cmds) begin
        rst = 1'b1;
        rdma_start = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; out_rdy = 1'b0;
        #1;
        check_reset_outputs("midjob_rst");
        rsp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        finished = 1; aborted = 1;
      end else begin
        rdma_start = (cyc + 1 == j.restart_cyc);
        w_rdma = 12'($urandom_range(1, 4)); h_rdma = 12'($urandom_range(1, 4));
        ch_rdma_div_Tout = 8'($urandom_range(1, 4));
        base_addr = $urandom(); surf_stride = $urandom(); line_stride = 16'($urandom());
        drive_random(j, cyc + 1);
      end
      cyc++;
    end
    if (!finished) check(1'b0, "timeout", 64'(cyc), 0);
    if (!aborted) begin
      check(done_cnt == 1, "done_count", 64'(done_cnt), 1);
      check(exp_cmd_q.size() == 0, "cmds_missing", 64'(exp_cmd_q.size()), 0);
      check(exp_pix_q.size() == 0, "pix_missing", 64'(exp_pix_q.size()), 0);
      if (j.exp_ncmds >= 0) begin
        check(ncmd == j.exp_ncmds, "ncmds", 64'(ncmd), 64'(j.exp_ncmds));
        check(npix == j.exp_npix, "npix", 64'(npix), 64'(j.exp_npix));
        if (j.exp_ncmds > 0) begin
          check(first_cmd == j.exp_first, "first_cmd", 64'(first_cmd), 64'(j.exp_first));
          check(last_cmd == j.exp_last, "last_cmd", 64'(last_cmd), 64'(j.exp_last));
        end
      end
    end
    rdma_start = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; out_rdy = 1'b0;
  endtask

  initial begin
    jobs[0] = mk(16, 2, 1, 32'h1000, 32'h0, 16'h400, 100, 100, 100, -1, 0, 0, 0,
                 2, 32, {4'd15, 32'h1000}, {4'd15, 32'h1400});
    jobs[1] = mk(20, 1, 2, 32'h0, 32'h8000, 16'h400, 100, 100, 100, 2, 0, 0, 0,
                 4, 40, {4'd15, 32'h0}, {4'd3, 32'h8200});
    jobs[2] = mk(64, 1, 1, 32'h3000, 32'h0, 16'h800, 100, 100, 100, -1, 40, 1, 0,
                 4, 64, {4'd15, 32'h3000}, {4'd15, 32'h3600});
    jobs[3] = mk(37, 3, 3, 32'h20000, 32'h10000, 16'h800, 50, 50, 50, -1, 0, 0, 0,
                 27, 333, {4'd15, 32'h20000}, {4'd4, 32'h41400});
    jobs[4] = mk(5, 2, 1, 32'hFFFFFF00, 32'h0, 16'h100, 100, 100, 100, -1, 0, 0, 0,
                 2, 10, {4'd4, 32'hFFFFFF00}, {4'd4, 32'h0});
    jobs[5] = mk(0, 5, 2, 32'h100, 32'h40, 16'h40, 100, 100, 100, -1, 0, 0, 0,
                 0, 0, 36'h0, 36'h0);
    jobs[6] = mk(17, 2, 2, 32'h100, 32'h4000, 16'h200, 70, 60, 70, -1, 0, 0, 0,
                 8, 68, {4'd15, 32'h100}, {4'd0, 32'h4500});
    jobs[7] = mk(4, 8, 1, 32'h5000, 32'h0, 16'h80, 100, 100, 100, -1, 0, 0, 3,
                 -1, 0, 36'h0, 36'h0);
    jobs[8] = jobs[0];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 9; i++) run_job(jobs[i]);

    for (int i = 0; i < 3; i++) begin
      rj = mk(int'($urandom_range(1, 40)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              $urandom(), $urandom(), 16'($urandom()),
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              -1, 0, 0, 0, -1, 0, 36'h0, 36'h0);
      run_job(rj);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
